// File: rtl/mt_cu_pkg.sv
// mt_cu_pkg: shared opcodes, ALU/type codes and the decoded-bundle layout
// for the multi-threaded control unit.
package mt_cu_pkg;

   localparam logic [6:0] OP_RR   = 7'b0110011;
   localparam logic [6:0] OP_RI   = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_SD   = 7'b0100011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_CUST = 7'b1111111;

   localparam logic [2:0] F3_DONE = 3'b000;
   localparam logic [2:0] F3_TCFG = 3'b001;
   localparam logic [2:0] F3_PAT  = 3'b001;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0010;
   localparam logic [3:0] ALU_AND = 4'b0011;
   localparam logic [3:0] ALU_SLL = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;

   localparam logic [3:0] ITYPE_RR   = 4'd0;
   localparam logic [3:0] ITYPE_RI   = 4'd1;
   localparam logic [3:0] ITYPE_LD   = 4'd2;
   localparam logic [3:0] ITYPE_SD   = 4'd3;
   localparam logic [3:0] ITYPE_LUI  = 4'd4;
   localparam logic [3:0] ITYPE_BR   = 4'd5;
   localparam logic [3:0] ITYPE_JAL  = 4'd6;
   localparam logic [3:0] ITYPE_JALR = 4'd7;

   localparam logic [2:0] BR_DEFAULT = 3'b010;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       mem_lw;
      logic       mem_sw;
      logic       reg_wr_en;
      logic       source_reg;
      logic       mem_pattern;
      logic [3:0] inst_type;
      logic [2:0] branch_specifier;
      logic       is_done;
      logic       is_tcfg;
   } dec_bundle_t;

   localparam dec_bundle_t BUNDLE_DEFAULT = '{
      alu_op: ALU_ADD, mem_lw: 1'b0, mem_sw: 1'b0, reg_wr_en: 1'b0,
      source_reg: 1'b0, mem_pattern: 1'b0, inst_type: ITYPE_RR,
      branch_specifier: BR_DEFAULT, is_done: 1'b0, is_tcfg: 1'b0};

   // shared funct3 -> ALU map for register and immediate arithmetic
   function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic sub);
      logic [3:0] op;
      op = ALU_ADD;
      case (f3)
         3'b000:  op = sub ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   function automatic logic arith_f3_bad(input logic [2:0] f3);
      return (f3 == 3'b010) || (f3 == 3'b011) || (f3 == 3'b100);
   endfunction

endpackage

// File: rtl/mt_cu_decode.sv
// mt_cu_decode: combinational instruction decoder.
// Build option MT_CU_ILLEGAL_TRAP_EN: flag illegal encodings and squash their
// write/memory side effects; without it illegal encodings decode to the
// default bundle and the illegal flag is tied low.
module mt_cu_decode
   import mt_cu_pkg::*;
#(
   parameter int PATTERN_AW = 5
) (
   input  logic [31:0]           inst,
   output dec_bundle_t           bundle,
   output logic [PATTERN_AW-1:0] pattern_addr,
   output logic                  illegal
);

   logic [6:0]            opcode;
   logic [2:0]            funct3;
   dec_bundle_t           raw;
   logic [PATTERN_AW-1:0] raw_paddr;
   logic                  raw_illegal;
   logic                  unused_inst;

   assign opcode      = inst[6:0];
   assign funct3      = inst[14:12];
   assign unused_inst = ^inst;

   // opcode/funct3 table lookup
   always_comb begin
      raw         = BUNDLE_DEFAULT;
      raw_paddr   = '0;
      raw_illegal = 1'b0;
      case (opcode)
         OP_RR: begin
            raw.reg_wr_en  = 1'b1;
            raw.source_reg = 1'b1;
            raw.inst_type  = ITYPE_RR;
            raw.alu_op     = alu_from_funct3(funct3, inst[30]);
            raw_illegal    = arith_f3_bad(funct3);
         end
         OP_RI: begin
            raw.reg_wr_en = 1'b1;
            raw.inst_type = ITYPE_RI;
            raw.alu_op    = alu_from_funct3(funct3, 1'b0);
            raw_illegal   = arith_f3_bad(funct3);
         end
         OP_LD: begin
            raw.reg_wr_en = 1'b1;
            raw.inst_type = ITYPE_LD;
            if (funct3 == F3_PAT) begin
               raw.mem_pattern = 1'b1;
               raw_paddr       = inst[31 -: PATTERN_AW];
            end else begin
               raw.mem_lw = 1'b1;
            end
         end
         OP_SD: begin
            raw.inst_type = ITYPE_SD;
            raw.mem_sw    = 1'b1;
         end
         OP_LUI: begin
            raw.inst_type = ITYPE_LUI;
            raw.reg_wr_en = 1'b1;
         end
         OP_BR: begin
            raw.source_reg       = 1'b1;
            raw.inst_type        = ITYPE_BR;
            raw.alu_op           = ALU_SUB;
            raw.branch_specifier = funct3;
         end
         OP_JAL: begin
            raw.reg_wr_en = 1'b1;
            raw.inst_type = ITYPE_JAL;
         end
         OP_JALR: begin
            raw.reg_wr_en = 1'b1;
            raw.inst_type = ITYPE_JALR;
         end
         OP_CUST: begin
            raw.is_done = (funct3 == F3_DONE);
            raw.is_tcfg = (funct3 == F3_TCFG);
            raw_illegal = (funct3 != F3_DONE) && (funct3 != F3_TCFG);
         end
         default: raw_illegal = 1'b1;
      endcase
   end

   // illegal-encoding policy
   always_comb begin
      bundle       = raw;
      pattern_addr = raw_paddr;
`ifdef MT_CU_ILLEGAL_TRAP_EN
      illegal = raw_illegal;
      if (raw_illegal) begin
         bundle.reg_wr_en   = 1'b0;
         bundle.mem_lw      = 1'b0;
         bundle.mem_sw      = 1'b0;
         bundle.mem_pattern = 1'b0;
      end
`else
      illegal = 1'b0;
      if (raw_illegal) begin
         bundle       = BUNDLE_DEFAULT;
         pattern_addr = '0;
      end
`endif
   end

endmodule

// File: rtl/mt_control_unit.sv
// mt_control_unit: per-thread decode stage with a single-entry output
// register, sticky per-thread done flags and the fetch thread scheduler.
// Build option MT_CU_ILLEGAL_TRAP_EN is handled inside mt_cu_decode.
module mt_control_unit
   import mt_cu_pkg::*;
#(
   parameter int NUM_THREADS = 4,
   parameter int THREAD_W    = $clog2(NUM_THREADS),
   parameter int PATTERN_AW  = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   restart,
   input  logic                   inst_valid,
   output logic                   inst_ready,
   input  logic [31:0]            inst,
   input  logic [THREAD_W-1:0]    inst_tid,
   output logic                   dec_valid,
   input  logic                   dec_ready,
   output logic [THREAD_W-1:0]    dec_tid,
   output logic [3:0]             alu_op,
   output logic                   mem_lw,
   output logic                   mem_sw,
   output logic                   reg_wr_en,
   output logic                   source_reg,
   output logic                   mem_pattern,
   output logic [3:0]             inst_type,
   output logic [PATTERN_AW-1:0]  pattern_addr,
   output logic [2:0]             branch_specifier,
   output logic                   dec_illegal,
   output logic [NUM_THREADS-1:0] thread_done,
   output logic                   all_done,
   output logic [THREAD_W-1:0]    sched_tid,
   output logic                   sched_mode
);

   dec_bundle_t           dec_bundle;
   logic [PATTERN_AW-1:0] dec_paddr;
   logic                  dec_ill;

   logic                   dec_valid_q, dec_valid_d;
   dec_bundle_t            bundle_q, bundle_d;
   logic [PATTERN_AW-1:0]  paddr_q, paddr_d;
   logic [THREAD_W-1:0]    tid_q, tid_d;
   logic                   illegal_q, illegal_d;
   logic [NUM_THREADS-1:0] done_q, done_d;
   logic                   mode_q, mode_d;
   logic [THREAD_W-1:0]    fixed_q, fixed_d;
   logic [THREAD_W-1:0]    rr_q, rr_d;
   logic [THREAD_W-1:0]    cand;
   logic                   accept, take;

   mt_cu_decode #(.PATTERN_AW(PATTERN_AW)) u_decode (
      .inst         (inst),
      .bundle       (dec_bundle),
      .pattern_addr (dec_paddr),
      .illegal      (dec_ill)
   );

   // a thread that has already signalled DONE is accepted but dropped
   assign inst_ready = !dec_valid_q || dec_ready;
   assign accept     = inst_valid && inst_ready;
   assign take       = accept && !done_q[inst_tid];

   // output register: load on take, drain on dec_ready, hold while stalled
   always_comb begin
      dec_valid_d = dec_valid_q;
      bundle_d    = bundle_q;
      paddr_d     = paddr_q;
      tid_d       = tid_q;
      illegal_d   = illegal_q;
      if (take) begin
         dec_valid_d = 1'b1;
         bundle_d    = dec_bundle;
         paddr_d     = dec_paddr;
         tid_d       = inst_tid;
         illegal_d   = dec_ill;
      end else if (dec_ready) begin
         dec_valid_d = 1'b0;
      end
   end

   // done flags and scheduler configuration; restart overrides same-cycle DONE/TCFG
   always_comb begin
      done_d  = done_q;
      mode_d  = mode_q;
      fixed_d = fixed_q;
      if (take && dec_bundle.is_done) done_d[inst_tid] = 1'b1;
      if (take && dec_bundle.is_tcfg) begin
         mode_d  = inst[20];
         fixed_d = inst[21 +: THREAD_W];
      end
      if (restart) begin
         done_d  = '0;
         mode_d  = 1'b0;
         fixed_d = '0;
      end
   end

   // round-robin pointer: nearest higher thread not done after this cycle's update;
   // scanning from the far end lets the closest candidate win, and no candidate means hold
   always_comb begin
      rr_d = rr_q;
      cand = '0;
      if (take && !mode_q) begin
         for (int i = NUM_THREADS; i >= 1; i--) begin
            cand = THREAD_W'((int'(rr_q) + i) % NUM_THREADS);
            if (!done_d[cand]) rr_d = cand;
         end
      end
      if (restart) rr_d = '0;
   end

   // state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_valid_q <= 1'b0;
         bundle_q    <= BUNDLE_DEFAULT;
         paddr_q     <= '0;
         tid_q       <= '0;
         illegal_q   <= 1'b0;
         done_q      <= '0;
         mode_q      <= 1'b0;
         fixed_q     <= '0;
         rr_q        <= '0;
      end else begin
         dec_valid_q <= dec_valid_d;
         bundle_q    <= bundle_d;
         paddr_q     <= paddr_d;
         tid_q       <= tid_d;
         illegal_q   <= illegal_d;
         done_q      <= done_d;
         mode_q      <= mode_d;
         fixed_q     <= fixed_d;
         rr_q        <= rr_d;
      end
   end

   assign dec_valid        = dec_valid_q;
   assign dec_tid          = tid_q;
   assign alu_op           = bundle_q.alu_op;
   assign mem_lw           = bundle_q.mem_lw;
   assign mem_sw           = bundle_q.mem_sw;
   assign reg_wr_en        = bundle_q.reg_wr_en;
   assign source_reg       = bundle_q.source_reg;
   assign mem_pattern      = bundle_q.mem_pattern;
   assign inst_type        = bundle_q.inst_type;
   assign branch_specifier = bundle_q.branch_specifier;
   assign pattern_addr     = paddr_q;
   assign dec_illegal      = illegal_q;
   assign thread_done      = done_q;
   assign all_done         = &done_q;
   assign sched_mode       = mode_q;
   assign sched_tid        = mode_q ? fixed_q : rr_q;

endmodule

// File: tb/tb_mt_control_unit.sv
// tb_mt_control_unit: directed stimulus, per-cycle comparison against a
// behavioural model of the control unit, plus hand-computed literal checks.
module tb_mt_control_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        restart;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [1:0]  inst_tid;
   logic        dec_valid;
   logic        dec_ready;
   logic [1:0]  dec_tid;
   logic [3:0]  alu_op;
   logic        mem_lw, mem_sw, reg_wr_en, source_reg, mem_pattern;
   logic [3:0]  inst_type;
   logic [4:0]  pattern_addr;
   logic [2:0]  branch_specifier;
   logic        dec_illegal;
   logic [3:0]  thread_done;
   logic        all_done;
   logic [1:0]  sched_tid;
   logic        sched_mode;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mt_control_unit #(.NUM_THREADS(4), .PATTERN_AW(5)) dut (
      .clk(clk), .rst(rst), .restart(restart),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_tid(inst_tid),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_tid(dec_tid),
      .alu_op(alu_op), .mem_lw(mem_lw), .mem_sw(mem_sw), .reg_wr_en(reg_wr_en),
      .source_reg(source_reg), .mem_pattern(mem_pattern), .inst_type(inst_type),
      .pattern_addr(pattern_addr), .branch_specifier(branch_specifier),
      .dec_illegal(dec_illegal), .thread_done(thread_done), .all_done(all_done),
      .sched_tid(sched_tid), .sched_mode(sched_mode)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [3:0] alu;
      logic       lw, sw, wr, src, pat;
      logic [3:0] typ;
      logic [4:0] paddr;
      logic [2:0] br;
      logic       ill, done, tcfg;
   } exp_t;

   function automatic exp_t default_exp();
      exp_t e;
      e    = '0;
      e.br = 3'b010;
      return e;
   endfunction

   function automatic exp_t ref_decode(input logic [31:0] w);
      exp_t       e;
      logic [3:0] alu_tab [8];
      logic [2:0] f3;
      alu_tab = '{4'h0, 4'h6, 4'h0, 4'h0, 4'h0, 4'h7, 4'h2, 4'h3};
      f3 = w[14:12];
      e  = default_exp();
      case (w[6:0])
         7'h33: begin
            e.wr = 1; e.src = 1; e.typ = 0; e.alu = alu_tab[f3];
            if (f3 == 0 && w[30]) e.alu = 4'h1;
            e.ill = f3 inside {3'd2, 3'd3, 3'd4};
         end
         7'h13: begin
            e.wr = 1; e.typ = 1; e.alu = alu_tab[f3];
            e.ill = f3 inside {3'd2, 3'd3, 3'd4};
         end
         7'h03: begin
            e.wr = 1; e.typ = 2;
            if (f3 == 1) begin e.pat = 1; e.paddr = w[31:27]; end
            else e.lw = 1;
         end
         7'h23: begin e.typ = 3; e.sw = 1; end
         7'h37: begin e.typ = 4; e.wr = 1; end
         7'h63: begin e.src = 1; e.typ = 5; e.alu = 4'h1; e.br = f3; end
         7'h6F: begin e.typ = 6; e.wr = 1; end
         7'h67: begin e.typ = 7; e.wr = 1; end
         7'h7F: begin e.done = (f3 == 0); e.tcfg = (f3 == 1); e.ill = (f3 > 1); end
         default: e.ill = 1;
      endcase
`ifdef MT_CU_ILLEGAL_TRAP_EN
      if (e.ill) begin e.wr = 0; e.lw = 0; e.sw = 0; e.pat = 0; end
`else
      if (e.ill) e = default_exp();
`endif
      return e;
   endfunction

   // next RR thread: smallest live thread above cur, else smallest live, else stay
   function automatic int rr_next(input int cur, input logic [3:0] d);
      int lo = -1;
      int hi = -1;
      for (int t = 0; t < 4; t++) begin
         if (!d[t]) begin
            if (lo < 0) lo = t;
            if (t > cur && hi < 0) hi = t;
         end
      end
      if (hi >= 0) return hi;
      if (lo >= 0) return lo;
      return cur;
   endfunction

   logic       m_valid;
   exp_t       m_b;
   logic [1:0] m_tid;
   logic [3:0] m_done;
   logic       m_mode;
   int         m_fixed;
   int         m_rr;

   always @(posedge clk or posedge rst) begin
      exp_t       e;
      logic       rdy;
      logic [3:0] nd;
      logic       adv;
      if (rst) begin
         m_valid = 0; m_b = default_exp(); m_tid = 0;
         m_done = 0; m_mode = 0; m_fixed = 0; m_rr = 0;
      end else begin
         rdy = !m_valid || dec_ready;
         if (inst_valid && rdy && !m_done[inst_tid]) begin
            e = ref_decode(inst);
            m_valid = 1; m_b = e; m_tid = inst_tid;
            nd = m_done;
            if (e.done) nd[inst_tid] = 1;
            adv = !m_mode;
            if (e.tcfg) begin m_mode = inst[20]; m_fixed = int'(inst[22:21]); end
            if (adv) m_rr = rr_next(m_rr, nd);
            m_done = nd;
         end else if (dec_ready) begin
            m_valid = 0;
         end
         if (restart) begin m_done = 0; m_mode = 0; m_fixed = 0; m_rr = 0; end
      end
      #1;
      chk("dec_valid", dec_valid, m_valid);
      chk("inst_ready", inst_ready, !m_valid || dec_ready);
      chk("thread_done", thread_done, m_done);
      chk("all_done", all_done, &m_done);
      chk("sched_mode", sched_mode, m_mode);
      chk("sched_tid", sched_tid, m_mode ? m_fixed : m_rr);
      if (m_valid) begin
         chk("dec_tid", dec_tid, m_tid);
         chk("alu_op", alu_op, m_b.alu);
         chk("mem_lw", mem_lw, m_b.lw);
         chk("mem_sw", mem_sw, m_b.sw);
         chk("reg_wr_en", reg_wr_en, m_b.wr);
         chk("source_reg", source_reg, m_b.src);
         chk("mem_pattern", mem_pattern, m_b.pat);
         chk("inst_type", inst_type, m_b.typ);
         chk("pattern_addr", pattern_addr, m_b.paddr);
         chk("branch_spec", branch_specifier, m_b.br);
         chk("dec_illegal", dec_illegal, m_b.ill);
      end
   end

   // ---------------- stimulus ----------------
   // returns on the falling edge after the instruction was accepted
   task automatic send(input logic [31:0] w, input int tid);
      int n = 0;
      bit r;
      @(negedge clk);
      inst = w; inst_tid = 2'(tid); inst_valid = 1;
      forever begin
         #1 r = inst_ready;
         @(negedge clk);
         if (r) break;
         n++;
         if (n > 20) begin
            n_vec++; n_fail++;
            $display("FAIL send_timeout: inst %h never accepted", w);
            break;
         end
      end
      inst_valid = 0;
   endtask

   task automatic pulse_restart();
      @(negedge clk); restart = 1;
      @(negedge clk); restart = 0;
   endtask

   logic [31:0] simple_vecs [10];
   int          rr_seq [4];
   logic [1:0]  held;

   initial begin
      rst = 1; restart = 0; inst_valid = 0; inst = 0; inst_tid = 0; dec_ready = 1;
      #2;
      chk("rst_dec_valid", dec_valid, 0);
      chk("rst_branch_spec", branch_specifier, 3'b010);
      chk("rst_sched", {sched_mode, sched_tid, thread_done}, 0);
      repeat (2) @(negedge clk);
      rst = 0;

      send(32'h4000_0033, 1);
      chk("sub_alu", alu_op, 4'b0001);
      chk("sub_wr_src", {reg_wr_en, source_reg}, 2'b11);
      chk("sub_type_tid", {inst_type, 2'(dec_tid)}, {4'd0, 2'd1});

      send(32'h1800_1003, 0);
      chk("pat_flags", {mem_pattern, mem_lw}, 2'b10);
      chk("pat_addr", pattern_addr, 5'd3);
      chk("pat_type_alu", {inst_type, alu_op}, {4'd2, 4'd0});

      // a spread of encodings, checked by the model
      simple_vecs = '{32'h0000_5063, 32'h1234_5037, 32'h0000_006F, 32'h0000_0067,
                      32'h0000_2023, 32'h0000_2003, 32'h0000_5013, 32'h0000_1013,
                      32'h0000_7013, 32'h0000_2033};
      foreach (simple_vecs[i]) send(simple_vecs[i], i % 4);

      // backpressure: two instructions offered while dec_ready is low
      @(negedge clk); dec_ready = 0;
      send(32'h0020_8033, 0);
      #1 chk("stall_ready", inst_ready, 0);
      fork
         send(32'h0020_E033, 1);
         begin repeat (3) @(negedge clk); dec_ready = 1; end
      join
      chk("stall_second_valid", dec_valid, 1);
      chk("stall_second_alu", alu_op, 4'b0010);
      chk("stall_second_tid", dec_tid, 2'd1);

      // round-robin with thread 2 done
      pulse_restart();
      send(32'h0000_007F, 2);
      chk("done_t2", thread_done, 4'b0100);
      rr_seq = '{3, 0, 1, 3};
      foreach (rr_seq[i]) begin
         send(32'h0000_0013, 0);
         chk("rr_seq", sched_tid, rr_seq[i]);
      end

      // retire remaining threads
      send(32'h0000_007F, 0);
      send(32'h0000_007F, 1);
      send(32'h0000_007F, 3);
      chk("all_done", all_done, 1);
      held = sched_tid;
      send(32'h0000_0013, 2);
      chk("drop_no_bundle", dec_valid, 0);
      chk("drop_sched_hold", sched_tid, held);

      // fixed-thread mode
      pulse_restart();
      send(32'h0070_107F, 0);
      chk("tcfg_mode", {sched_mode, sched_tid}, 3'b111);
      send(32'h0000_0013, 1);
      send(32'h0000_0013, 2);
      chk("fixed_hold", sched_tid, 2'd3);
      pulse_restart();
      chk("restart_sched", {sched_mode, sched_tid, thread_done}, 0);

      // restart beats a same-cycle DONE
      fork
         send(32'h0000_007F, 1);
         begin @(negedge clk); restart = 1; @(negedge clk); restart = 0; end
      join
      chk("restart_wins", thread_done, 4'b0000);

      // illegal encodings
      send(32'h0000_000B, 0);
`ifdef MT_CU_ILLEGAL_TRAP_EN
      chk("illegal_flag", dec_illegal, 1);
      chk("illegal_wr", reg_wr_en, 0);
`else
      chk("illegal_flag", dec_illegal, 0);
      chk("illegal_default", {alu_op, inst_type, branch_specifier, reg_wr_en}, {4'd0, 4'd0, 3'b010, 1'b0});
`endif
      send(32'h0000_207F, 0);
      chk("bad_custom_nodone", thread_done, 4'b0000);

      // reset in the middle of a stall
      @(negedge clk); dec_ready = 0;
      send(32'h0000_0013, 0);
      #3 rst = 1;
      #1 chk("rst_async_valid", dec_valid, 0);
      @(negedge clk); rst = 0; dec_ready = 1;
      send(32'h0000_0033, 3);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
